md_unit: RTL and testbench

Parametrised multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. It sits in the E stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands and holds the 64-bit-equivalent result for a configurable number of cycles, modelling a multi-cycle datapath. It supersedes the combinational HI/LO read mux: `rd_data` serves MFHI/MFLO, and `busy` drives the D-stage stall for every HI/LO-touching instruction.

---
 rtl/md_unit.sv | 121 ++++++++++++
 tb/tb_md_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Results are captured on accept and committed to HI/LO when the busy countdown expires.
module md_unit #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic [WIDTH-1:0] res_hi_reg, res_hi_next;
    logic [WIDTH-1:0] res_lo_reg, res_lo_next;
    logic [WIDTH-1:0] hi_next, lo_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             pend_valid_reg, pend_valid_next;
    logic             busy_next;
    logic             accept;

    // Multiplier: sign- or zero-extend to 2*WIDTH; the low 2*WIDTH bits of the product are exact.
    logic             is_signed;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod;

    assign is_signed = (op == OP_MULT) || (op == OP_DIV);
    assign ext_a = {{WIDTH{is_signed & a[WIDTH-1]}}, a};
    assign ext_b = {{WIDTH{is_signed & b[WIDTH-1]}}, b};
    assign prod  = ext_a * ext_b;

    // Divider works on magnitudes; -2^(W-1) / -1 falls out as quotient -2^(W-1), remainder 0.
    logic             neg_a, neg_b;
    logic [WIDTH-1:0] mag_a, mag_b, div_b, uq, ur, quot, rem;

    assign neg_a = is_signed & a[WIDTH-1];
    assign neg_b = is_signed & b[WIDTH-1];
    assign mag_a = neg_a ? (~a + 1'b1) : a;
    assign mag_b = neg_b ? (~b + 1'b1) : b;
    assign div_b = (b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
    assign uq    = mag_a / div_b;
    assign ur    = mag_a % div_b;
    assign quot  = (neg_a ^ neg_b) ? (~uq + 1'b1) : uq;
    assign rem   = neg_a ? (~ur + 1'b1) : ur;

    assign accept = start && !flush && !busy;

    always_comb begin
        hi_next         = hi;
        lo_next         = lo;
        res_hi_next     = res_hi_reg;
        res_lo_next     = res_lo_reg;
        cnt_next        = cnt_reg;
        pend_valid_next = pend_valid_reg;
        if (accept) begin
            case (op)
                OP_MULT, OP_MULTU: begin
                    res_hi_next     = prod[2*WIDTH-1:WIDTH];
                    res_lo_next     = prod[WIDTH-1:0];
                    cnt_next        = CNT_W'(MULT_LAT);
                    pend_valid_next = 1'b1;
                end
                OP_DIV, OP_DIVU: begin
                    res_hi_next     = rem;
                    res_lo_next     = quot;
                    cnt_next        = CNT_W'(DIV_LAT);
                    pend_valid_next = (b != '0);
                end
                OP_MTHI: hi_next = a;
                OP_MTLO: lo_next = a;
                default: ;
            endcase
        end else if (cnt_reg != '0) begin
            cnt_next = cnt_reg - 1'b1;
            if (cnt_reg == CNT_W'(1) && pend_valid_reg) begin
                hi_next         = res_hi_reg;
                lo_next         = res_lo_reg;
                pend_valid_next = 1'b0;
            end
        end
        busy_next = (cnt_next != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi             <= '0;
            lo             <= '0;
            res_hi_reg     <= '0;
            res_lo_reg     <= '0;
            cnt_reg        <= '0;
            pend_valid_reg <= 1'b0;
            busy           <= 1'b0;
        end else begin
            hi             <= hi_next;
            lo             <= lo_next;
            res_hi_reg     <= res_hi_next;
            res_lo_reg     <= res_lo_next;
            cnt_reg        <= cnt_next;
            pend_valid_reg <= pend_valid_next;
            busy           <= busy_next;
        end
    end

    assign rd_data = rd_sel ? lo : hi;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: default-latency unit plus a LAT=1 instance on the same stimulus.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic        flush = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        rd_sel = 1'b0;
    logic [31:0] rd_data, hi, lo;
    logic        busy;
    logic [31:0] f_rd_data, f_hi, f_lo;
    logic        f_busy;

    int n_cmp = 0;
    int n_err = 0;
    int n;

    always #5 clk = ~clk;

    md_unit #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .flush(flush),
        .a(a), .b(b), .rd_sel(rd_sel), .rd_data(rd_data), .busy(busy),
        .hi(hi), .lo(lo)
    );

    md_unit #(.WIDTH(32), .MULT_LAT(1), .DIV_LAT(1), .CNT_W(4)) fast (
        .clk(clk), .reset(reset), .start(start), .op(op), .flush(flush),
        .a(a), .b(b), .rd_sel(rd_sel), .rd_data(f_rd_data), .busy(f_busy),
        .hi(f_hi), .lo(f_lo)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-16s observed %h expected %h", tag, obs, exp);
    endtask

    // Present a command for one edge; returns in the first cycle after acceptance.
    task automatic issue(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                         input logic fl);
        start = 1'b1; op = o; a = va; b = vb; flush = fl;
        cyc();
        start = 1'b0; flush = 1'b0;
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy && cnt < 50) begin
            cnt++;
            cyc();
        end
    endtask

    initial begin
        // Reset state
        cyc(); cyc();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_rd", rd_data, 32'd0);
        reset = 1'b1;
        cyc();

        // MULT -2 * 3; the LAT=1 instance is busy exactly one cycle
        issue(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
        check("mult_busy1", {31'd0, busy}, 32'd1);
        check("fast_busy1", {31'd0, f_busy}, 32'd1);
        cyc();
        check("fast_busy2", {31'd0, f_busy}, 32'd0);
        check("fast_lo", f_lo, 32'hFFFF_FFFA);
        check("mult_hold_lo", lo, 32'd0);
        wait_idle(n);
        check("mult_lat", n, 32'd4);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);
        rd_sel = 1'b1; #1;
        check("mult_rd_lo", rd_data, 32'hFFFF_FFFA);

        // MULTU issued in the first idle cycle (zero bubble)
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_idle(n);
        check("multu_lat", n, 32'd5);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);

        // DIV -7 / 2
        issue(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        wait_idle(n);
        check("div_lat", n, 32'd10);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        // DIV overflow
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_idle(n);
        check("divov_lo", lo, 32'h8000_0000);
        check("divov_hi", hi, 32'h0000_0000);

        // MTHI visible next cycle, no busy
        issue(3'd4, 32'h0000_1234, 32'd0, 1'b0);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        check("mthi_hi", hi, 32'h0000_1234);
        rd_sel = 1'b0; #1;
        check("mthi_rd_hi", rd_data, 32'h0000_1234);

        // DIVU by zero: busy full latency, HI/LO untouched
        issue(3'd3, 32'd5, 32'd0, 1'b0);
        wait_idle(n);
        check("divz_lat", n, 32'd10);
        check("divz_hi", hi, 32'h0000_1234);
        check("divz_lo", lo, 32'h8000_0000);

        // DIVU 100 / 7
        issue(3'd3, 32'd100, 32'd7, 1'b0);
        wait_idle(n);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        // Flushed MULT is ignored
        issue(3'd0, 32'd2, 32'd3, 1'b1);
        check("flush_busy", {31'd0, busy}, 32'd0);
        cyc();
        check("flush_hi", hi, 32'd2);
        check("flush_lo", lo, 32'd14);

        // MTLO while busy is ignored
        issue(3'd0, 32'd7, 32'd6, 1'b0);
        cyc();
        issue(3'd5, 32'h0000_0055, 32'd0, 1'b0);
        wait_idle(n);
        check("mtlo_ign_lat", n, 32'd3);
        check("mtlo_ign_lo", lo, 32'd42);
        check("mtlo_ign_hi", hi, 32'd0);

        // Async reset at busy cycle 3 of a DIVU
        issue(3'd3, 32'd100, 32'd7, 1'b0);
        cyc(); cyc();
        check("arst_pre_busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_lo", lo, 32'd0);
        check("arst_hi", hi, 32'd0);
        cyc(); cyc();
        reset = 1'b1;
        for (int i = 0; i < 12; i++) cyc();
        check("arst_post_busy", {31'd0, busy}, 32'd0);
        check("arst_post_hi", hi, 32'd0);
        check("arst_post_lo", lo, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
